seq_gen: RTL and testbench

Serial sequence generator: the transmit end of the single-bit `w` stream consumed by the lab's sequence-detector FSMs. It loads a parallel bit pattern on `start`, then drives it LSB-first onto `w` one bit per accepted cycle. It presents a `valid`/`ready` handshake so a detector, or a bench standing in for one, can stall the stream. It exposes its FSM state on `State` for board LEDs and debug, matching the detector blocks.

---
 rtl/seq_gen.sv | 125 ++++++++++++
 tb/tb_seq_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// seq_gen: parallel-load, LSB-first serial pattern transmitter with valid/ready stall.
// Optional SEQ_GEN_REPEAT_EN adds a 'loop' input that restarts the frame back-to-back.
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             ready,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             loop,
`endif
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [LW-1:0]    cnt_r, cnt_s;
  logic             done_r, done_s;
  logic [LW-1:0]    len_clamp_s;
`ifdef SEQ_GEN_REPEAT_EN
  logic [WIDTH-1:0] reload_r, reload_s;
  logic [LW-1:0]    len_r, len_s;
`endif

  // Lengths beyond the shift register are clamped so no phantom zero bits are sent.
  assign len_clamp_s = (len > LW'(WIDTH - 1)) ? LW'(WIDTH - 1) : len;

  // Next-state and datapath update logic.
  always_comb begin
    state_s  = state_r;
    shreg_s  = shreg_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
    reload_s = reload_r;
    len_s    = len_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          shreg_s  = pattern;
          cnt_s    = len_clamp_s;
          state_s  = SEND;
`ifdef SEQ_GEN_REPEAT_EN
          reload_s = pattern;
          len_s    = len_clamp_s;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (ready) begin
          if (cnt_r != {LW{1'b0}}) begin
            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
            cnt_s   = cnt_r - LW'(1);
          end else begin
            done_s = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
            if (loop) begin
              shreg_s = reload_r;
              cnt_s   = len_r;
              state_s = SEND;
            end else begin
              state_s = DONE;
            end
`else
            state_s = DONE;
`endif
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      shreg_r  <= {WIDTH{1'b0}};
      cnt_r    <= {LW{1'b0}};
      done_r   <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      reload_r <= {WIDTH{1'b0}};
      len_r    <= {LW{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      shreg_r  <= shreg_s;
      cnt_r    <= cnt_s;
      done_r   <= done_s;
`ifdef SEQ_GEN_REPEAT_EN
      reload_r <= reload_s;
      len_r    <= len_s;
`endif
    end
  end

  // Outputs decode registered state only, so ready/start never reach them combinationally.
  assign valid = (state_r == SEND);
  assign busy  = (state_r == SEND) || (state_r == DONE);
  assign w     = valid & shreg_r[0];
  assign done  = done_r;
  assign State = state_r;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: per-cycle vector table plus hand-written reset and clamping sequences.
// Repeat vectors are included when SEQ_GEN_REPEAT_EN is defined.
module tb_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] len;
  logic       ready;
  logic       w, valid, busy, done;
  logic [1:0] state;
`ifdef SEQ_GEN_REPEAT_EN
  logic       loop;
`endif

  logic       start6;
  logic [5:0] pattern6;
  logic [2:0] len6;
  logic       ready6;
  logic       w6, valid6, busy6, done6;
  logic [1:0] state6;
`ifdef SEQ_GEN_REPEAT_EN
  logic       loop6;
`endif

  int checks;
  int errors;

  typedef struct {
    logic       s;
    logic [7:0] p;
    logic [2:0] l;
    logic       rdy;
    logic       lp;
    logic       ew;
    logic       ev;
    logic       eb;
    logic       ed;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[$];

  seq_gen #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .ready(ready),
`ifdef SEQ_GEN_REPEAT_EN
    .loop(loop),
`endif
    .w(w), .valid(valid), .busy(busy), .done(done), .State(state)
  );

  seq_gen #(.WIDTH(6)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .pattern(pattern6), .len(len6), .ready(ready6),
`ifdef SEQ_GEN_REPEAT_EN
    .loop(loop6),
`endif
    .w(w6), .valid(valid6), .busy(busy6), .done(done6), .State(state6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [7:0] p, input logic [2:0] l,
                              input logic rdy, input logic lp, input logic ew, input logic ev,
                              input logic eb, input logic ed, input logic [1:0] est);
    vec_t v;
    v.s = s; v.p = p; v.l = l; v.rdy = rdy; v.lp = lp;
    v.ew = ew; v.ev = ev; v.eb = eb; v.ed = ed; v.est = est;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ew, input logic ev, input logic eb,
                            input logic ed, input logic [1:0] est);
    check({tag, ".w"},     {7'd0, w},     {7'd0, ew});
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
    check({tag, ".busy"},  {7'd0, busy},  {7'd0, eb});
    check({tag, ".done"},  {7'd0, done},  {7'd0, ed});
    check({tag, ".State"}, {6'd0, state}, {6'd0, est});
  endtask

  initial begin
    logic [7:0] pat;
    logic [5:0] pat6;
    checks = 0;
    errors = 0;

    // basic frame 1011_0010, len 7
    vecs.push_back(mk(1'b1, 8'hB2, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    // stall on bit 2 for two cycles
    vecs.push_back(mk(1'b1, 8'hB2, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    // single-bit frame with a stall on its only bit
    vecs.push_back(mk(1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    // start while busy is ignored and not queued
    vecs.push_back(mk(1'b1, 8'hB2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
`ifdef SEQ_GEN_REPEAT_EN
    // back-to-back repeat of 0000_0110, len 2
    vecs.push_back(mk(1'b1, 8'h06, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
`endif

    reset = 1'b0; start = 1'b0; pattern = 8'h00; len = 3'd0; ready = 1'b0;
    start6 = 1'b0; pattern6 = 6'd0; len6 = 3'd0; ready6 = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
    loop = 1'b0; loop6 = 1'b0;
`endif
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outs("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start   = vecs[i].s;
      pattern = vecs[i].p;
      len     = vecs[i].l;
      ready   = vecs[i].rdy;
`ifdef SEQ_GEN_REPEAT_EN
      loop    = vecs[i].lp;
`endif
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ew, vecs[i].ev, vecs[i].eb, vecs[i].ed, vecs[i].est);
    end

    // reset during bit 4 clears outputs before the next edge
    @(negedge clk);
    start = 1'b1; pattern = 8'hB2; len = 3'd7; ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_outs("mid_bit4", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outs("after_release", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    pat = 8'h81;
    @(negedge clk);
    start = 1'b1; pattern = pat; len = 3'd7; ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_outs($sformatf("restart_bit%0d", k), pat[k], 1'b1, 1'b1, 1'b0, 2'd1);
      @(posedge clk); #1;
    end
    check_outs("restart_done", 1'b0, 1'b0, 1'b1, 1'b1, 2'd2);

    // WIDTH=6 instance: len 7 clamps to 6 bits
    pat6 = 6'b101101;
    @(negedge clk);
    start6 = 1'b1; pattern6 = pat6; len6 = 3'd7; ready6 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("clamp_w%0d", k), {7'd0, w6}, {7'd0, pat6[k]});
      check($sformatf("clamp_valid%0d", k), {7'd0, valid6}, 8'd1);
      @(posedge clk); #1;
    end
    check("clamp_done", {7'd0, done6}, 8'd1);
    check("clamp_state", {6'd0, state6}, 8'd2);
    check("clamp_valid_end", {7'd0, valid6}, 8'd0);
    @(posedge clk); #1;
    check("clamp_idle", {6'd0, state6}, 8'd0);
    check("clamp_busy_end", {7'd0, busy6}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
